rx_i2s: RTL and testbench

Receive-side counterpart of the I2S transmitter. It oversamples an external I2S bus (BCLK, LRCK, SDATA) on one system clock and recovers left/right sample pairs at 16, 24 or 32 bits. It serializes each pair into a byte stream, MSB first, left channel before right, in the same byte order the transmitter's output FIFO consumes. It sits between an ADC/S/PDIF-receiver I2S port and the FT2232H upstream FIFO path.

---
 rtl/rx_i2s_pkg.sv | 34 +++
 rtl/i2s_rx_sync.sv | 39 +++
 rtl/rx_i2s.sv | 139 +++++++++++++
 tb/tb_rx_i2s.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_i2s_pkg.sv
// Shared definitions for the I2S receive path: bit-depth codes, receive
// state type and small depth-decoding helpers.
package rx_i2s_pkg;

    localparam logic [1:0] BIT_DEPTH_16  = 2'd0;
    localparam logic [1:0] BIT_DEPTH_24  = 2'd1;
    localparam logic [1:0] BIT_DEPTH_32  = 2'd2;
    localparam logic [1:0] BIT_DEPTH_DOP = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LEFT,
        RIGHT
    } rx_state_t;

    // DoP frames carry 24-bit words on the wire.
    function automatic logic [5:0] depth_bits(input logic [1:0] depth);
        case (depth)
            BIT_DEPTH_16: return 6'd16;
            BIT_DEPTH_32: return 6'd32;
            default:      return 6'd24;
        endcase
    endfunction

    function automatic logic [3:0] byte_count(input logic [1:0] depth);
        case (depth)
            BIT_DEPTH_16: return 4'd4;
            BIT_DEPTH_32: return 4'd8;
            default:      return 4'd6;
        endcase
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-stage synchronizer for BCLK/LRCK/SDATA with a BCLK rising-edge
// detector on the synchronized clock.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bclk,
    input  logic lrck,
    input  logic sdata,
    output logic rise,
    output logic lrck_s,
    output logic sdata_s
);

    logic [SYNC_STAGES-1:0] bclk_pipe;
    logic [SYNC_STAGES-1:0] lrck_pipe;
    logic [SYNC_STAGES-1:0] sdata_pipe;
    logic                   bclk_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_pipe  <= '0;
            lrck_pipe  <= '0;
            sdata_pipe <= '0;
            bclk_prev  <= 1'b0;
        end else begin
            bclk_pipe  <= {bclk_pipe[SYNC_STAGES-2:0], bclk};
            lrck_pipe  <= {lrck_pipe[SYNC_STAGES-2:0], lrck};
            sdata_pipe <= {sdata_pipe[SYNC_STAGES-2:0], sdata};
            bclk_prev  <= bclk_pipe[SYNC_STAGES-1];
        end
    end

    assign rise    = bclk_pipe[SYNC_STAGES-1] & ~bclk_prev;
    assign lrck_s  = lrck_pipe[SYNC_STAGES-1];
    assign sdata_s = sdata_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/rx_i2s.sv
// I2S receiver: frame-aligns to LRCK, assembles left/right words and streams
// each pair out as bytes, MSB first, left channel before right.
module rx_i2s
    import rx_i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    input  logic [1:0] bit_depth_i,
    input  logic       bclk_i,
    input  logic       lrck_i,
    input  logic       sdata_i,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    input  logic       rd_ready_i,
    output logic       locked_o,
    output logic       overrun_o
);

    rx_state_t   state, state_next;
    logic        rise, lrck_s, sdata_s;
    logic [1:0]  depth;
    logic [5:0]  nbits;
    logic        lrck_prev;
    logic [5:0]  bit_cnt;
    logic [4:0]  pos;
    logic [31:0] word, word_next, left_word;
    logic [63:0] hold, pair;
    logic [3:0]  remain;
    logic        busy, overrun;
    logic        sync_hit, to_right, to_left, handshake, last_byte;

    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .bclk    (bclk_i),
        .lrck    (lrck_i),
        .sdata   (sdata_i),
        .rise    (rise),
        .lrck_s  (lrck_s),
        .sdata_s (sdata_s)
    );

    assign nbits     = depth_bits(depth);
    assign sync_hit  = rise && state == SYNC  && !lrck_s &&  lrck_prev;
    assign to_right  = rise && state == LEFT  &&  lrck_s && !lrck_prev;
    assign to_left   = rise && state == RIGHT && !lrck_s &&  lrck_prev;
    assign handshake = busy && rd_ready_i;
    assign last_byte = handshake && remain == 4'd1;
    assign pos       = 5'(nbits - 6'd1 - bit_cnt);

    // Bits beyond the configured depth fall off; unfilled LSBs stay zero.
    always_comb begin
        word_next = word;
        if (bit_cnt < nbits) word_next[pos] = sdata_s;
    end

    always_comb begin
        case (depth)
            BIT_DEPTH_16: pair = {left_word[15:0], word_next[15:0], 32'h0};
            BIT_DEPTH_32: pair = {left_word, word_next};
            default:      pair = {left_word[23:0], word_next[23:0], 16'h0};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!en_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = SYNC;
                SYNC:    if (sync_hit) state_next = LEFT;
                LEFT:    if (to_right) state_next = RIGHT;
                RIGHT:   if (to_left)  state_next = LEFT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || !en_i) begin
            depth     <= BIT_DEPTH_16;
            lrck_prev <= 1'b0;
            bit_cnt   <= '0;
            word      <= '0;
            left_word <= '0;
            hold      <= '0;
            remain    <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (state == IDLE || state == SYNC) depth <= bit_depth_i;
            if (rise && state != IDLE) lrck_prev <= lrck_s;

            if (sync_hit) begin
                bit_cnt <= '0;
                word    <= '0;
            end else if (rise && (state == LEFT || state == RIGHT)) begin
                if (to_right || to_left) begin
                    bit_cnt <= '0;
                    word    <= '0;
                end else begin
                    word    <= word_next;
                    bit_cnt <= (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
                end
                if (to_right) left_word <= word_next;
            end

            // A pair landing on the final handshake replaces it without loss.
            if (to_left && (!busy || last_byte)) begin
                hold   <= pair;
                remain <= byte_count(depth);
                busy   <= 1'b1;
            end else begin
                if (to_left) overrun <= 1'b1;
                if (handshake) begin
                    hold   <= {hold[55:0], 8'h00};
                    remain <= remain - 4'd1;
                    if (remain == 4'd1) busy <= 1'b0;
                end
            end
        end
    end

    assign rd_data_o  = hold[63:56];
    assign rd_valid_o = busy;
    assign locked_o   = (state == LEFT) || (state == RIGHT);
    assign overrun_o  = overrun;

endmodule

// File: tb/tb_rx_i2s.sv
// Directed bench for rx_i2s: table of frame vectors plus hand-written
// backpressure, overrun, enable-drop and reset sequences.
module tb_rx_i2s;
    import rx_i2s_pkg::*;

    logic       clk_i       = 1'b0;
    logic       reset_n_i   = 1'b0;
    logic       en_i        = 1'b0;
    logic [1:0] bit_depth_i = BIT_DEPTH_16;
    logic       bclk_i      = 1'b0;
    logic       lrck_i      = 1'b0;
    logic       sdata_i     = 1'b0;
    logic       rd_ready_i  = 1'b1;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       locked_o;
    logic       overrun_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    int         overrun_cnt = 0;
    int         ready_mode  = 0;
    int         ready_phase = 0;
    logic       check_hold  = 1'b0;
    logic       last_stall  = 1'b0;
    logic [7:0] last_data   = 8'h00;

    typedef struct {
        logic [1:0]  depth;
        int          width;
        logic [31:0] left;
        logic [31:0] right;
        int          nbytes;
        logic [63:0] bytes;
    } vec_t;

    vec_t vecs[6];

    rx_i2s #(.SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .en_i        (en_i),
        .bit_depth_i (bit_depth_i),
        .bclk_i      (bclk_i),
        .lrck_i      (lrck_i),
        .sdata_i     (sdata_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .locked_o    (locked_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Consumer side: collect handshaken bytes, count overruns, check stalls.
    always @(negedge clk_i) begin
        if (rd_valid_o && rd_ready_i) got_q.push_back(rd_data_o);
        if (overrun_o) overrun_cnt++;
        if (check_hold && last_stall) begin
            check_output("stall_valid", 64'(rd_valid_o), 64'd1);
            check_output("stall_data", 64'(rd_data_o), 64'(last_data));
        end
        last_stall = rd_valid_o && !rd_ready_i;
        last_data  = rd_data_o;
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        case (ready_mode)
            0: rd_ready_i = 1'b1;
            1: rd_ready_i = 1'b0;
            default: begin
                rd_ready_i  = (ready_phase == 0) || (ready_phase == 3);
                ready_phase = (ready_phase + 1) % 4;
            end
        endcase
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic send_bit(input logic l, input logic d);
        lrck_i  = l;
        sdata_i = d;
        #40;
        bclk_i = 1'b1;
        #40;
        bclk_i = 1'b0;
    endtask

    // LRCK flips on the last bit of each word, one BCLK ahead of the next MSB.
    task automatic send_word(input logic [31:0] w, input int width, input logic chan);
        for (int i = 0; i < width; i++)
            send_bit((i == width - 1) ? ~chan : chan, w[width-1-i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int width);
        send_word(l, width, 1'b0);
        send_word(r, width, 1'b1);
    endtask

    task automatic preamble();
        repeat (4) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
    endtask

    task automatic restart(input logic [1:0] depth);
        en_i        = 1'b0;
        bit_depth_i = depth;
        wait_clks(3);
        got_q.delete();
        overrun_cnt = 0;
        en_i        = 1'b1;
        wait_clks(2);
    endtask

    task automatic check_bytes(input string name, input logic [63:0] exp_bytes, input int n);
        logic [7:0] b;
        check_output({name, "_count"}, 64'(got_q.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            b = (k < got_q.size()) ? got_q[k] : 8'hxx;
            check_output($sformatf("%s_byte%0d", name, k), 64'(b), 64'(exp_bytes[63-8*k -: 8]));
        end
    endtask

    task automatic apply_stimulus(input int idx);
        restart(vecs[idx].depth);
        check_output($sformatf("vec%0d_locked_presync", idx), 64'(locked_o), 64'd0);
        preamble();
        send_frame(vecs[idx].left, vecs[idx].right, vecs[idx].width);
        wait_clks(20);
        check_output($sformatf("vec%0d_locked", idx), 64'(locked_o), 64'd1);
        check_bytes($sformatf("vec%0d", idx), vecs[idx].bytes, vecs[idx].nbytes);
        check_output($sformatf("vec%0d_overrun", idx), 64'(overrun_cnt), 64'd0);
    endtask

    initial begin
        vecs[0] = '{BIT_DEPTH_16,  16, 32'h0000A55A, 32'h00001234, 4, 64'hA55A1234_00000000};
        vecs[1] = '{BIT_DEPTH_24,  32, 32'h800001A5, 32'h7FFFFE5A, 6, 64'h800001_7FFFFE_0000};
        vecs[2] = '{BIT_DEPTH_32,  32, 32'hDEADBEEF, 32'h01020304, 8, 64'hDEADBEEF_01020304};
        vecs[3] = '{BIT_DEPTH_24,  16, 32'h0000CAFE, 32'h0000BEEF, 6, 64'hCAFE00_BEEF00_0000};
        vecs[4] = '{BIT_DEPTH_DOP, 24, 32'h00123456, 32'h00ABCDEF, 6, 64'h123456_ABCDEF_0000};
        vecs[5] = '{BIT_DEPTH_16,  32, 32'hFFFF0000, 32'h0001FFFF, 4, 64'hFFFF0001_00000000};

        wait_clks(3);
        check_output("reset_valid", 64'(rd_valid_o), 64'd0);
        check_output("reset_data", 64'(rd_data_o), 64'h00);
        check_output("reset_locked", 64'(locked_o), 64'd0);
        check_output("reset_overrun", 64'(overrun_o), 64'd0);
        reset_n_i = 1'b1;
        wait_clks(2);

        for (int i = 0; i < 6; i++) apply_stimulus(i);

        // Consumer stalled across two frames: first pair held, second dropped.
        ready_mode = 1;
        restart(BIT_DEPTH_16);
        preamble();
        send_frame(32'hA55A, 32'h1234, 16);
        wait_clks(5);
        check_output("ovr_valid_held", 64'(rd_valid_o), 64'd1);
        check_output("ovr_data_held", 64'(rd_data_o), 64'hA5);
        send_frame(32'h1111, 32'h2222, 16);
        wait_clks(5);
        check_output("ovr_pulses", 64'(overrun_cnt), 64'd1);
        check_output("ovr_data_still", 64'(rd_data_o), 64'hA5);
        ready_mode = 0;
        wait_clks(20);
        check_bytes("ovr", 64'hA55A1234_00000000, 4);
        check_output("ovr_locked", 64'(locked_o), 64'd1);

        // Ready pattern 1,0,0,1 over three back-to-back 32-bit frames.
        restart(BIT_DEPTH_32);
        ready_mode = 2;
        check_hold = 1'b1;
        preamble();
        send_frame(32'hDEADBEEF, 32'h01020304, 32);
        send_frame(32'hCAFEF00D, 32'h12345678, 32);
        send_frame(32'h0BADC0DE, 32'h8899AABB, 32);
        wait_clks(40);
        check_hold = 1'b0;
        ready_mode = 0;
        wait_clks(2);
        check_output("bp_count", 64'(got_q.size()), 64'd24);
        begin
            logic [7:0] bp_exp[24];
            bp_exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
                       8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h78,
                       8'h0B, 8'hAD, 8'hC0, 8'hDE, 8'h88, 8'h99, 8'hAA, 8'hBB};
            for (int k = 0; k < 24; k++)
                check_output($sformatf("bp_byte%0d", k),
                             64'((k < got_q.size()) ? got_q[k] : 8'hxx), 64'(bp_exp[k]));
        end
        check_output("bp_overrun", 64'(overrun_cnt), 64'd0);

        // Enable dropped mid right word: partial pair never appears.
        restart(BIT_DEPTH_16);
        preamble();
        send_word(32'hA55A, 16, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'(16'h1234 >> (15 - i)));
        en_i = 1'b0;
        wait_clks(2);
        check_output("endrop_valid", 64'(rd_valid_o), 64'd0);
        check_output("endrop_locked", 64'(locked_o), 64'd0);
        en_i = 1'b1;
        wait_clks(2);
        check_output("reen_locked_before_sync", 64'(locked_o), 64'd0);
        for (int i = 8; i < 16; i++) send_bit((i == 15) ? 1'b0 : 1'b1, 1'(16'h1234 >> (15 - i)));
        wait_clks(10);
        check_output("reen_locked_after_sync", 64'(locked_o), 64'd1);
        check_output("reen_no_partial", 64'(got_q.size()), 64'd0);
        send_frame(32'h5AA5, 32'h0F0F, 16);
        wait_clks(20);
        check_bytes("reen", 64'h5AA50F0F_00000000, 4);

        // Reset while bytes are pending: everything is discarded.
        ready_mode = 1;
        restart(BIT_DEPTH_16);
        preamble();
        send_frame(32'h1357, 32'h2468, 16);
        wait_clks(3);
        check_output("rst_valid_before", 64'(rd_valid_o), 64'd1);
        reset_n_i = 1'b0;
        wait_clks(1);
        check_output("rst_valid", 64'(rd_valid_o), 64'd0);
        check_output("rst_data", 64'(rd_data_o), 64'h00);
        check_output("rst_locked", 64'(locked_o), 64'd0);
        reset_n_i  = 1'b1;
        ready_mode = 0;
        wait_clks(10);
        check_output("rst_no_bytes", 64'(got_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
